// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: counter encodings and PC slicing helpers.
package bp_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // Table index is pc[idx_w+1:2], returned zero-extended to 32 bits.
  function automatic logic [31:0] pc_index(input logic [31:0] pc, input int unsigned idx_w);
    return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  // BTB tag is pc[idx_w+tag_w+1:idx_w+2], returned zero-extended to 32 bits.
  function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int unsigned idx_w,
                                         input int unsigned tag_w);
    return (pc >> (idx_w + 2)) & ((32'd1 << tag_w) - 32'd1);
  endfunction

endpackage

// File: rtl/sat_counter2.sv
// Next-state function of a 2-bit saturating direction counter.
module sat_counter2
  import bp_pkg::*;
(
  input  logic [1:0] cnt,
  input  logic       taken,
  output logic [1:0] next_cnt_c
);

  always_comb begin
    next_cnt_c = cnt;
    if (taken) begin
      if (cnt != ST) next_cnt_c = cnt + 2'd1;
    end else begin
      if (cnt != SNT) next_cnt_c = cnt - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BHT + tagged BTB predictor with combinational lookup, trained
// by resolved branches, plus mispredict pulse and performance counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned IDX_W = 6,
  parameter int unsigned TAG_W = 8,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      lk_pc,
  output logic             lk_taken,
  output logic [31:0]      lk_target,
  input  logic             up_valid,
  input  logic [31:0]      up_pc,
  input  logic             up_taken,
  input  logic [31:0]      up_target,
  input  logic             up_pred_taken,
  input  logic [31:0]      up_pred_target,
  output logic             mispredict,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int unsigned DEPTH = 1 << IDX_W;

  logic [1:0]       bht        [DEPTH];
  logic             btb_valid  [DEPTH];
  logic [TAG_W-1:0] btb_tag    [DEPTH];
  logic [31:0]      btb_target [DEPTH];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic [1:0]       bht_next_c;
  logic             wrong_c;

  assign lk_idx = IDX_W'(pc_index(lk_pc, IDX_W));
  assign lk_tag = TAG_W'(pc_tag(lk_pc, IDX_W, TAG_W));
  assign up_idx = IDX_W'(pc_index(up_pc, IDX_W));
  assign up_tag = TAG_W'(pc_tag(up_pc, IDX_W, TAG_W));

  // Lookup reads the registered tables directly, so a same-cycle update is not bypassed.
  always_comb begin
    lk_taken  = bht[lk_idx][1] & btb_valid[lk_idx] & (btb_tag[lk_idx] == lk_tag);
    lk_target = lk_taken ? btb_target[lk_idx] : lk_pc + 32'd4;
  end

  sat_counter2 u_sat (
    .cnt        (bht[up_idx]),
    .taken      (up_taken),
    .next_cnt_c (bht_next_c)
  );

  always_comb begin
    wrong_c = (up_pred_taken != up_taken) | (up_taken & (up_pred_target != up_target));
  end

  // Direction counters and BTB valid bits; reset discards any concurrent update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        bht[i]       <= WNT;
        btb_valid[i] <= 1'b0;
      end
    end else if (up_valid) begin
      bht[up_idx] <= bht_next_c;
      if (up_taken) btb_valid[up_idx] <= 1'b1;
    end
  end

  // Tag/target payload is qualified by btb_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (rst_n && up_valid && up_taken) begin
      btb_tag[up_idx]    <= up_tag;
      btb_target[up_idx] <= up_target;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mispredict  <= 1'b0;
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      mispredict <= up_valid & wrong_c;
      if (up_valid) begin
        branch_cnt <= branch_cnt + CNT_W'(1);
        if (wrong_c) mispred_cnt <= mispred_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor.
module tb_branch_predictor;

  logic        clk;
  logic        rst_n;
  logic [31:0] lk_pc;
  logic        lk_taken;
  logic [31:0] lk_target;
  logic        up_valid;
  logic [31:0] up_pc;
  logic        up_taken;
  logic [31:0] up_target;
  logic        up_pred_taken;
  logic [31:0] up_pred_target;
  logic        mispredict;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  int errors = 0;
  int checks = 0;

  branch_predictor #(.IDX_W(6), .TAG_W(8), .CNT_W(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .lk_pc          (lk_pc),
    .lk_taken       (lk_taken),
    .lk_target      (lk_target),
    .up_valid       (up_valid),
    .up_pc          (up_pc),
    .up_taken       (up_taken),
    .up_target      (up_target),
    .up_pred_taken  (up_pred_taken),
    .up_pred_target (up_pred_target),
    .mispredict     (mispredict),
    .branch_cnt     (branch_cnt),
    .mispred_cnt    (mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one resolved branch for exactly one posedge; returns at the following negedge.
  task automatic do_update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                           input logic ptk, input logic [31:0] ptgt);
    @(negedge clk);
    up_valid = 1'b1; up_pc = pc; up_taken = tk; up_target = tgt;
    up_pred_taken = ptk; up_pred_target = ptgt;
    @(negedge clk);
    up_valid = 1'b0;
  endtask

  task automatic set_lookup(input logic [31:0] pc);
    lk_pc = pc;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; up_valid = 1'b0; lk_pc = 32'h0;
    up_pc = '0; up_taken = 1'b0; up_target = '0; up_pred_taken = 1'b0; up_pred_target = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    set_lookup(32'h100);
    checks++; if (lk_taken !== 1'b0) begin errors++; $display("FAIL reset_lk_taken got=%0b exp=0", lk_taken); end
    checks++; if (lk_target !== 32'h104) begin errors++; $display("FAIL reset_lk_target got=%h exp=00000104", lk_target); end
    checks++; if (branch_cnt !== 32'd0) begin errors++; $display("FAIL reset_branch_cnt got=%0d exp=0", branch_cnt); end
    checks++; if (mispred_cnt !== 32'd0) begin errors++; $display("FAIL reset_mispred_cnt got=%0d exp=0", mispred_cnt); end
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL reset_mispredict got=%0b exp=0", mispredict); end
  endtask

  task automatic test_train();
    do_update(32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL train1_mispredict got=%0b exp=1", mispredict); end
    do_update(32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL train2_mispredict got=%0b exp=1", mispredict); end
    set_lookup(32'h100);
    checks++; if (lk_taken !== 1'b1) begin errors++; $display("FAIL train_lk_taken got=%0b exp=1", lk_taken); end
    checks++; if (lk_target !== 32'h200) begin errors++; $display("FAIL train_lk_target got=%h exp=00000200", lk_target); end
    checks++; if (branch_cnt !== 32'd2) begin errors++; $display("FAIL train_branch_cnt got=%0d exp=2", branch_cnt); end
    checks++; if (mispred_cnt !== 32'd2) begin errors++; $display("FAIL train_mispred_cnt got=%0d exp=2", mispred_cnt); end
    @(negedge clk);
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL idle_mispredict got=%0b exp=0", mispredict); end
  endtask

  task automatic test_saturation();
    // Counter starts at ST (11).
    do_update(32'h100, 1'b0, 32'h0, 1'b1, 32'h200);
    set_lookup(32'h100);
    checks++; if (lk_taken !== 1'b1) begin errors++; $display("FAIL sat1_lk_taken got=%0b exp=1", lk_taken); end
    do_update(32'h100, 1'b0, 32'h0, 1'b1, 32'h200);
    set_lookup(32'h100);
    checks++; if (lk_taken !== 1'b0) begin errors++; $display("FAIL sat2_lk_taken got=%0b exp=0", lk_taken); end
    checks++; if (lk_target !== 32'h104) begin errors++; $display("FAIL sat2_lk_target got=%h exp=00000104", lk_target); end
    do_update(32'h100, 1'b0, 32'h0, 1'b1, 32'h200);
    do_update(32'h100, 1'b0, 32'h0, 1'b1, 32'h200);
    // One taken step from a floor of 00 must still predict not-taken.
    do_update(32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
    set_lookup(32'h100);
    checks++; if (lk_taken !== 1'b0) begin errors++; $display("FAIL sat_floor_lk_taken got=%0b exp=0", lk_taken); end
    do_update(32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
    set_lookup(32'h100);
    checks++; if (lk_taken !== 1'b1) begin errors++; $display("FAIL sat_rise_lk_taken got=%0b exp=1", lk_taken); end
    checks++; if (branch_cnt !== 32'd8) begin errors++; $display("FAIL sat_branch_cnt got=%0d exp=8", branch_cnt); end
    checks++; if (mispred_cnt !== 32'd8) begin errors++; $display("FAIL sat_mispred_cnt got=%0d exp=8", mispred_cnt); end
  endtask

  task automatic test_correct();
    do_update(32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL correct_mispredict got=%0b exp=0", mispredict); end
    checks++; if (branch_cnt !== 32'd9) begin errors++; $display("FAIL correct_branch_cnt got=%0d exp=9", branch_cnt); end
    checks++; if (mispred_cnt !== 32'd8) begin errors++; $display("FAIL correct_mispred_cnt got=%0d exp=8", mispred_cnt); end
  endtask

  task automatic test_alias();
    do_update(32'h200, 1'b1, 32'h300, 1'b0, 32'h0);
    set_lookup(32'h100);
    checks++; if (lk_taken !== 1'b0) begin errors++; $display("FAIL alias_old_lk_taken got=%0b exp=0", lk_taken); end
    checks++; if (lk_target !== 32'h104) begin errors++; $display("FAIL alias_old_lk_target got=%h exp=00000104", lk_target); end
    set_lookup(32'h200);
    checks++; if (lk_taken !== 1'b1) begin errors++; $display("FAIL alias_new_lk_taken got=%0b exp=1", lk_taken); end
    checks++; if (lk_target !== 32'h300) begin errors++; $display("FAIL alias_new_lk_target got=%h exp=00000300", lk_target); end
  endtask

  task automatic test_same_cycle();
    @(negedge clk);
    up_valid = 1'b1; up_pc = 32'h100; up_taken = 1'b1; up_target = 32'h200;
    up_pred_taken = 1'b1; up_pred_target = 32'h204;
    set_lookup(32'h100);
    checks++; if (lk_taken !== 1'b0) begin errors++; $display("FAIL same_old_lk_taken got=%0b exp=0", lk_taken); end
    checks++; if (lk_target !== 32'h104) begin errors++; $display("FAIL same_old_lk_target got=%h exp=00000104", lk_target); end
    @(negedge clk);
    up_valid = 1'b0;
    #1;
    checks++; if (lk_taken !== 1'b1) begin errors++; $display("FAIL same_new_lk_taken got=%0b exp=1", lk_taken); end
    checks++; if (lk_target !== 32'h200) begin errors++; $display("FAIL same_new_lk_target got=%h exp=00000200", lk_target); end
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL same_target_mispredict got=%0b exp=1", mispredict); end
    checks++; if (mispred_cnt !== 32'd10) begin errors++; $display("FAIL same_mispred_cnt got=%0d exp=10", mispred_cnt); end
  endtask

  task automatic test_idle_x();
    @(negedge clk);
    up_valid = 1'b0; up_pc = 'x; up_taken = 1'bx; up_target = 'x;
    up_pred_taken = 1'bx; up_pred_target = 'x;
    repeat (2) @(negedge clk);
    set_lookup(32'h100);
    checks++; if (lk_target !== 32'h200) begin errors++; $display("FAIL idle_x_lk_target got=%h exp=00000200", lk_target); end
    checks++; if (branch_cnt !== 32'd11) begin errors++; $display("FAIL idle_x_branch_cnt got=%0d exp=11", branch_cnt); end
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL idle_x_mispredict got=%0b exp=0", mispredict); end
  endtask

  task automatic test_wrap();
    set_lookup(32'hFFFF_FFFC);
    checks++; if (lk_taken !== 1'b0) begin errors++; $display("FAIL wrap_lk_taken got=%0b exp=0", lk_taken); end
    checks++; if (lk_target !== 32'h0) begin errors++; $display("FAIL wrap_lk_target got=%h exp=00000000", lk_target); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    rst_n = 1'b0;
    up_valid = 1'b1; up_pc = 32'h100; up_taken = 1'b1; up_target = 32'h240;
    up_pred_taken = 1'b0; up_pred_target = 32'h0;
    @(negedge clk);
    up_valid = 1'b0;
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL rstmid_mispredict got=%0b exp=0", mispredict); end
    checks++; if (branch_cnt !== 32'd0) begin errors++; $display("FAIL rstmid_branch_cnt got=%0d exp=0", branch_cnt); end
    checks++; if (mispred_cnt !== 32'd0) begin errors++; $display("FAIL rstmid_mispred_cnt got=%0d exp=0", mispred_cnt); end
    rst_n = 1'b1;
    set_lookup(32'h100);
    checks++; if (lk_taken !== 1'b0) begin errors++; $display("FAIL rstmid_lk100_taken got=%0b exp=0", lk_taken); end
    checks++; if (lk_target !== 32'h104) begin errors++; $display("FAIL rstmid_lk100_target got=%h exp=00000104", lk_target); end
    set_lookup(32'h200);
    checks++; if (lk_taken !== 1'b0) begin errors++; $display("FAIL rstmid_lk200_taken got=%0b exp=0", lk_taken); end
    // Counters reset to WNT: one taken update must reach WT and predict taken.
    do_update(32'h100, 1'b1, 32'h280, 1'b0, 32'h0);
    set_lookup(32'h100);
    checks++; if (lk_taken !== 1'b1) begin errors++; $display("FAIL rstmid_wnt_lk_taken got=%0b exp=1", lk_taken); end
    checks++; if (lk_target !== 32'h280) begin errors++; $display("FAIL rstmid_wnt_lk_target got=%h exp=00000280", lk_target); end
    checks++; if (branch_cnt !== 32'd1) begin errors++; $display("FAIL rstmid_branch_cnt_after got=%0d exp=1", branch_cnt); end
  endtask

  initial begin
    test_reset();
    test_train();
    test_saturation();
    test_correct();
    test_alias();
    test_same_cycle();
    test_idle_x();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch predictor paired with the branch comparator: predicts direction and target in fetch, and is trained by the resolved outcome (BranchTaken, target) from execute.
- Direct-mapped table of 2-bit saturating counters (BHT) plus a tagged branch target buffer (BTB).
- Keeps mispredict/branch performance counters for the core's debug readout.

Parameters:
- IDX_W, 6, index bits; the table has 2**IDX_W entries and is indexed by pc[IDX_W+1:2].
- TAG_W, 8, BTB tag bits, taken from pc[IDX_W+TAG_W+1:IDX_W+2].
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- lk_pc  in  32  fetch PC to look up.
- lk_taken  out  1  predicted taken (combinational from lk_pc).
- lk_target  out  32  predicted target; equals lk_pc+4 when lk_taken=0.
- up_valid  in  1  a resolved conditional branch is presented this cycle.
- up_pc  in  32  PC of the resolved branch.
- up_taken  in  1  resolved outcome (BranchTaken).
- up_target  in  32  resolved taken target.
- up_pred_taken  in  1  prediction made for this branch at fetch (carried down the pipe).
- up_pred_target  in  32  target predicted at fetch.
- mispredict  out  1  registered; pulses 1 cycle after an up_valid whose prediction was wrong.
- branch_cnt  out  CNT_W  resolved branches since reset.
- mispred_cnt  out  CNT_W  mispredictions since reset.

Behaviour:
- Reset (rst_n=0 sampled at posedge):
  - all BHT counters = 2'b01 (weakly not-taken);
  - all BTB valid bits = 0; tag and target are don't-care;
  - mispredict=0, branch_cnt=0, mispred_cnt=0.
  - Reset wins over a simultaneous up_valid.
  - Reset mid-operation discards any pending training.
  - Lookup outputs during reset follow the table as it currently stands; after reset they give not-taken.
- Lookup (combinational, zero latency):
  - lk_taken = BHT[i][1] AND btb_valid[i] AND btb_tag[i]==tag(lk_pc).
  - lk_target = btb_target[i] if lk_taken, else lk_pc+4 (32-bit wrap: 0xFFFFFFFC+4 = 0).
- Update (at posedge when up_valid=1, using index/tag from up_pc):
  - BHT counter saturates: increment if up_taken (max 3), decrement if not (min 0).
  - If up_taken: BTB entry gets valid=1, tag=tag(up_pc), target=up_target. This replaces an aliased tag, and a tag miss then allocates.
  - If not taken: BTB entry is unchanged.
  - A BHT entry is shared between aliased PCs; it is not reset on a tag mismatch.
- Mispredict is wrong = (up_pred_taken != up_taken) OR (up_taken AND up_pred_target != up_target).
  - mispredict <= up_valid AND wrong, registered with 1-cycle latency.
  - mispredict is 0 in any cycle following up_valid=0.
- Counters:
  - branch_cnt += 1 on each up_valid.
  - mispred_cnt += 1 when up_valid AND wrong.
  - Both wrap modulo 2**CNT_W with no saturation.
- Same-index lookup and update in one cycle: the lookup sees pre-update contents, with no bypass. The new state is visible from the next cycle.
- up_* inputs are ignored when up_valid=0; X on them must not corrupt state.

Decomposition:
- Shared package bp_pkg holds:
  - localparams for the counter encodings SNT=00, WNT=01, WT=10, ST=11;
  - the index and tag slice helper functions used by both the lookup and update paths.
- Natural sub-module: sat_counter2, a pure function/module computing the next 2-bit counter value from (cnt, taken).
- Tables are flops in the top-level (64 entries by default). No SRAM macro.

Test Plan:
- Reset then lookup pc=0x100 -> lk_taken=0, lk_target=0x104; branch_cnt=0, mispred_cnt=0.
- Two updates pc=0x100 taken target 0x200, pred_taken=0 -> counter 01→10→11. Next-cycle lookup 0x100 -> lk_taken=1, lk_target=0x200. mispredict pulses 1 after each update; mispred_cnt=2, branch_cnt=2.
- Saturation: from ST, three not-taken updates on 0x100 -> lookup not-taken after the 2nd. Counter ends at 00 and stays 00 after a 4th.
- Alias: train 0x100 taken→0x200, then update 0x200 (same index, IDX_W=6) taken→0x300. Lookup 0x100 -> tag miss, lk_taken=0. Lookup 0x200 -> 0x300.
- Same-cycle lookup/update of 0x100: lookup returns the old prediction; the next cycle returns the new one. Taken with correct direction but pred_target 0x204≠0x200 -> mispredict=1.
- Assert rst_n=0 with up_valid=1 after training -> all tables and counters are cleared and no mispredict pulse occurs.
